// File: rtl/cnn_win_pkg.sv
// Shared types and helpers for the CNN window generator.
package cnn_win_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ADV   = 2'd2,
    DONE  = 2'd3
  } win_state_t;

  function automatic int pix_per_byte(input int pix_w);
    return 32'sd8 / pix_w;
  endfunction

endpackage

// File: rtl/cnn_pix_ram.sv
// Frame pixel store: simple dual-port RAM, one write port and one registered
// read port. The array itself is not reset.
module cnn_pix_ram #(
  parameter int DEPTH  = 784,
  parameter int WIDTH  = 1,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cnn_window_gen.sv
// Sliding KxK window generator: unpacks input bytes into a frame RAM and streams
// every valid window, one pixel per cycle. Define CNN_WIN_PIPE_EN for an extra output stage.
module cnn_window_gen
  import cnn_win_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int PIX_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_clr,
  input  logic             in_vld,
  input  logic [7:0]       in_data,
  output logic             in_rdy,
  input  logic             win_rdy,
  output logic             pix_vld,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_first,
  output logic             pix_last,
  output logic             win_last,
  output logic             frame_done,
  output logic             overflow
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int PPB  = pix_per_byte(PIX_W);
  localparam int AW   = $clog2(NPIX + 1);
  localparam int RAW  = $clog2(NPIX);
  localparam int KW   = $clog2(K);
  localparam int CW   = $clog2(PPB + 1);
  localparam int LW   = $clog2(IMG_W);

  localparam logic [AW-1:0] NPIX_A     = AW'(NPIX);
  localparam logic [AW-1:0] ANCHOR0    = AW'((K - 1) * IMG_W + K - 1);
  localparam logic [AW-1:0] ANCHOR_END = AW'(NPIX - 1);
  localparam logic [AW-1:0] ROW_STEP   = AW'(IMG_W - K + 1);
  localparam logic [AW-1:0] K_A        = AW'(K);
  localparam logic [KW-1:0] K_LAST     = KW'(K - 1);
  localparam logic [LW-1:0] COL_LAST   = LW'(IMG_W - K);
  localparam logic [CW-1:0] PPB_C      = CW'(PPB);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [7:0]       byte_q, byte_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_rdy_q, in_rdy_d;
  logic             ovf_q, ovf_d;
  logic             wr_en_s;

  win_state_t       state_q, state_d;
  logic [AW-1:0]    anchor_q, anchor_d;
  logic [LW-1:0]    col_q, col_d;
  logic [KW-1:0]    r_q, r_d, c_q, c_d;
  logic [AW-1:0]    off_q, off_d;

  logic             rd_en_s;
  logic [RAW-1:0]   rd_addr_s;
  logic [PIX_W-1:0] rdata_s;
  logic             vld1_q, vld1_d, first1_q, first1_d, last1_q, last1_d;
  logic             wlast1_q, wlast1_d, done_q, done_d;

  cnn_pix_ram #(
    .DEPTH (NPIX),
    .WIDTH (PIX_W),
    .ADDR_W(RAW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en_s),
    .waddr(RAW'(wr_ptr_q)),
    .wdata(byte_q[PIX_W-1:0]),
    .re   (rd_en_s),
    .raddr(rd_addr_s),
    .rdata(rdata_s)
  );

  // Unpacker: latch an accepted byte, then write one pixel per cycle, LSB first.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    byte_d   = byte_q;
    cnt_d    = cnt_q;
    in_rdy_d = in_rdy_q;
    ovf_d    = ovf_q;
    wr_en_s  = 1'b0;
    if (cnt_q != '0) begin
      wr_en_s  = (wr_ptr_q != NPIX_A);
      wr_ptr_d = wr_en_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
      byte_d   = byte_q >> PIX_W;
      cnt_d    = cnt_q - 1'b1;
      in_rdy_d = (cnt_q == CW'(1));
    end else begin
      wr_en_s  = 1'b0;
    end
    if (in_vld) begin
      if (in_rdy_q && (wr_ptr_q != NPIX_A)) begin
        byte_d   = in_data;
        cnt_d    = PPB_C;
        in_rdy_d = 1'b0;
      end else begin
        ovf_d    = 1'b1;
      end
    end else begin
      ovf_d = ovf_q;
    end
    if (frame_clr) begin
      wr_ptr_d = '0;
      byte_d   = '0;
      cnt_d    = '0;
      in_rdy_d = 1'b1;
      ovf_d    = 1'b0;
    end else begin
      ovf_d = ovf_d;
    end
  end

  // Read FSM state and window position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      byte_q   <= '0;
      cnt_q    <= '0;
      in_rdy_q <= 1'b1;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      anchor_q <= ANCHOR0;
      col_q    <= '0;
      r_q      <= '0;
      c_q      <= '0;
      off_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      byte_q   <= byte_d;
      cnt_q    <= cnt_d;
      in_rdy_q <= in_rdy_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      anchor_q <= anchor_d;
      col_q    <= col_d;
      r_q      <= r_d;
      c_q      <= c_d;
      off_q    <= off_d;
    end
  end

  // Next state; off_q is the offset of the current fetch from the window's top-left pixel.
  always_comb begin
    state_d  = state_q;
    anchor_d = anchor_q;
    col_d    = col_q;
    r_d      = r_q;
    c_d      = c_q;
    off_d    = off_q;
    case (state_q)
      IDLE: begin
        if (win_rdy && (anchor_q < wr_ptr_q)) begin
          state_d = FETCH;
          r_d     = '0;
          c_d     = '0;
          off_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (c_q == K_LAST) begin
          c_d   = '0;
          r_d   = r_q + 1'b1;
          off_d = off_q + ROW_STEP;
          state_d = (r_q == K_LAST) ? ADV : FETCH;
        end else begin
          c_d   = c_q + 1'b1;
          off_d = off_q + 1'b1;
        end
      end
      ADV: begin
        if (col_q == COL_LAST) begin
          col_d    = '0;
          anchor_d = anchor_q + K_A;
        end else begin
          col_d    = col_q + 1'b1;
          anchor_d = anchor_q + 1'b1;
        end
        state_d = (anchor_q == ANCHOR_END) ? DONE : IDLE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (frame_clr) begin
      state_d  = IDLE;
      anchor_d = ANCHOR0;
      col_d    = '0;
      r_d      = '0;
      c_d      = '0;
      off_d    = '0;
    end else begin
      state_d = state_d;
    end
  end

  // Read address and sideband flags; they reach the outputs with the RAM data.
  always_comb begin
    rd_en_s   = (state_q == FETCH);
    rd_addr_s = RAW'(anchor_q - ANCHOR0 + off_q);
    vld1_d    = rd_en_s && !frame_clr;
    first1_d  = vld1_d && (r_q == '0) && (c_q == '0);
    last1_d   = vld1_d && (r_q == K_LAST) && (c_q == K_LAST);
    wlast1_d  = last1_d && (anchor_q == ANCHOR_END);
    done_d    = (state_d == DONE);
  end

  // First output stage, aligned with the RAM read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q   <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      wlast1_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      vld1_q   <= vld1_d;
      first1_q <= first1_d;
      last1_q  <= last1_d;
      wlast1_q <= wlast1_d;
      done_q   <= done_d;
    end
  end

`ifdef CNN_WIN_PIPE_EN
  logic             vld2_q, vld2_d, first2_q, first2_d, last2_q, last2_d, wlast2_q, wlast2_d;
  logic [PIX_W-1:0] data2_q, data2_d;

  // Extra output stage; a frame clear also kills the pixel held here.
  always_comb begin
    vld2_d   = vld1_q && !frame_clr;
    first2_d = first1_q && vld2_d;
    last2_d  = last1_q && vld2_d;
    wlast2_d = wlast1_q && vld2_d;
    data2_d  = vld2_d ? rdata_s : '0;
  end

  // Output register of the extra stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld2_q   <= 1'b0;
      first2_q <= 1'b0;
      last2_q  <= 1'b0;
      wlast2_q <= 1'b0;
      data2_q  <= '0;
    end else begin
      vld2_q   <= vld2_d;
      first2_q <= first2_d;
      last2_q  <= last2_d;
      wlast2_q <= wlast2_d;
      data2_q  <= data2_d;
    end
  end

  assign pix_vld   = vld2_q;
  assign pix_data  = data2_q;
  assign pix_first = first2_q;
  assign pix_last  = last2_q;
  assign win_last  = wlast2_q;
`else
  assign pix_vld   = vld1_q;
  assign pix_data  = vld1_q ? rdata_s : '0;
  assign pix_first = first1_q;
  assign pix_last  = last1_q;
  assign win_last  = wlast1_q;
`endif

  assign in_rdy     = in_rdy_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Self-checking bench for cnn_window_gen: a 28x28/K3/1-bit instance and an
// 8x6/K5/8-bit instance, checked against a window model built from the image.
module tb_cnn_window_gen;

`ifdef CNN_WIN_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic fc_a, iv_a, ir_a, wr_a, pv_a, pf_a, pl_a, wl_a, fd_a, ov_a;
  logic [7:0] id_a;
  logic [0:0] pd_a;
  logic fc_b, iv_b, ir_b, wr_b, pv_b, pf_b, pl_b, wl_b, fd_b, ov_b;
  logic [7:0] id_b, pd_b;

  cnn_window_gen #(.IMG_W(28), .IMG_H(28), .K(3), .PIX_W(1)) u_a (
    .clk(clk), .rst_n(rst_n), .frame_clr(fc_a), .in_vld(iv_a), .in_data(id_a),
    .in_rdy(ir_a), .win_rdy(wr_a), .pix_vld(pv_a), .pix_data(pd_a),
    .pix_first(pf_a), .pix_last(pl_a), .win_last(wl_a), .frame_done(fd_a),
    .overflow(ov_a)
  );

  cnn_window_gen #(.IMG_W(8), .IMG_H(6), .K(5), .PIX_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .frame_clr(fc_b), .in_vld(iv_b), .in_data(id_b),
    .in_rdy(ir_b), .win_rdy(wr_b), .pix_vld(pv_b), .pix_data(pd_b),
    .pix_first(pf_b), .pix_last(pl_b), .win_last(wl_b), .frame_done(fd_b),
    .overflow(ov_b)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  d;
    logic        f;
    logic        l;
    logic        wl;
  } ent_t;

  ent_t qa[$], qb[$], chkq[$];
  logic [7:0] img [0:1023];
  int n_cmp = 0;
  int n_fail = 0;
  int wptr = 0;
  int unsigned n0;

  always @(negedge clk) begin
    if (pv_a) qa.push_back('{cyc: cyc, d: {7'd0, pd_a}, f: pf_a, l: pl_a, wl: wl_a});
    if (pv_b) qb.push_back('{cyc: cyc, d: pd_b, f: pf_b, l: pl_b, wl: wl_b});
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b, input bit extra);
    iv_a = 1'b1; id_a = b;
    tick(1);
    iv_a = 1'b0;
    for (int j = 0; j < 8; j++) img[wptr + j] = {7'd0, b[j]};
    wptr += 8;
    if (extra) begin
      tick(1);
      iv_a = 1'b1; id_a = ~b;
      tick(1);
      iv_a = 1'b0;
    end
    for (int t = 0; t < 20 && !ir_a; t++) tick(1);
    chk("a_in_rdy_back", 256'(ir_a), 256'(1));
  endtask

  task automatic send_b(input logic [7:0] b);
    iv_b = 1'b1; id_b = b;
    tick(1);
    iv_b = 1'b0;
    img[wptr] = b;
    wptr += 1;
    for (int t = 0; t < 20 && !ir_b; t++) tick(1);
    chk("b_in_rdy_back", 256'(ir_b), 256'(1));
  endtask

  // Window w covers rows w/(w_img-k+1).. and cols w%(w_img-k+1).., read row-major.
  task automatic check_frame(input string tag, input int w, input int h, input int k);
    int nw, kk, wpr, r, c;
    ent_t e;
    logic [255:0] od, ed, of, ef;
    nw  = (w - k + 1) * (h - k + 1);
    kk  = k * k;
    wpr = w - k + 1;
    chk({tag, "_count"}, 256'(chkq.size()), 256'(nw * kk));
    for (int win = 0; win < nw; win++) begin
      if ((win + 1) * kk > chkq.size()) break;
      od = '0; ed = '0; of = '0; ef = '0;
      for (int i = 0; i < kk; i++) begin
        e = chkq[win * kk + i];
        r = i / k;
        c = i % k;
        od[i*8 +: 8] = e.d;
        ed[i*8 +: 8] = img[(win / wpr + r) * w + (win % wpr) + c];
        of[i] = e.f;
        of[64 + i] = e.l;
        of[128 + i] = e.wl;
        of[192 + i] = (e.cyc == chkq[win * kk].cyc + 32'(i));
        ef[192 + i] = 1'b1;
      end
      ef[0] = 1'b1;
      ef[64 + kk - 1] = 1'b1;
      ef[128 + kk - 1] = (win == nw - 1);
      chk($sformatf("%s_win%0d_data", tag, win), od, ed);
      chk($sformatf("%s_win%0d_flags", tag, win), of, ef);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fc_a = 1'b0; iv_a = 1'b0; id_a = 8'd0; wr_a = 1'b0;
    fc_b = 1'b0; iv_b = 1'b0; id_b = 8'd0; wr_b = 1'b0;
    tick(3);
    chk("a_reset", 256'({ir_a, pv_a, pf_a, pl_a, wl_a, fd_a, ov_a, pd_a}), 256'(8'b10000000));
    chk("b_reset", 256'({ir_b, pv_b, pf_b, pl_b, wl_b, fd_b, ov_b, pd_b}), 256'(15'h4000));
    rst_n = 1'b1;
    tick(2);

    // Full random frame with the core always ready; nothing may start before pixel 58.
    wr_a = 1'b1;
    wptr = 0;
    for (int i = 0; i < 7; i++) send_a(8'($urandom_range(0, 255)), 1'b0);
    tick(20);
    chk("a_nowin_before_px58", 256'(qa.size()), 256'(0));
    for (int i = 7; i < 98; i++) send_a(8'($urandom_range(0, 255)), 1'b0);
    for (int t = 0; t < 12000 && !fd_a; t++) tick(1);
    chk("a_frame_done", 256'(fd_a), 256'(1));
    chk("a_no_ovf", 256'(ov_a), 256'(0));
    chkq = qa;
    check_frame("a1", 28, 28, 3);

    // Frame clear, then a byte dropped while the unpacker is busy.
    fc_a = 1'b1;
    tick(1);
    fc_a = 1'b0;
    chk("a_clr_state", 256'({ir_a, pv_a, fd_a, ov_a}), 256'(4'b1000));
    qa.delete();
    wptr = 0;
    send_a(8'($urandom_range(0, 255)), 1'b1);
    chk("a_ovf_set", 256'(ov_a), 256'(1));
    for (int i = 1; i < 7; i++) send_a(8'($urandom_range(0, 255)), 1'b0);
    tick(20);
    chk("a_ovf_ptr_by8", 256'(qa.size()), 256'(0));
    chk("a_ovf_sticky", 256'(ov_a), 256'(1));

    // Core busy: data present but no window until win_rdy rises.
    wr_a = 1'b0;
    send_a(8'($urandom_range(0, 255)), 1'b0);
    tick(50);
    chk("a_hold_no_rdy", 256'(qa.size()), 256'(0));
    n0 = cyc;
    wr_a = 1'b1;
    for (int t = 0; t < 20 && qa.size() == 0; t++) tick(1);
    chk("a_start_latency", 256'(qa.size() > 0 ? qa[0].cyc : 32'd0), 256'(n0 + 1 + LAT));

    // Abort on the 4th pixel of the fetch.
    while (cyc < n0 + 4 + LAT) tick(1);
    fc_a = 1'b1;
    tick(1);
    fc_a = 1'b0;
    chk("a_abort_vld", 256'(pv_a), 256'(0));
    tick(5);
    chk("a_abort_count", 256'(qa.size()), 256'(4));
    if (qa.size() >= 4)
      chk("a_abort_data", 256'({qa[0].d, qa[1].d, qa[2].d, qa[3].d}),
          256'({img[0], img[1], img[2], img[28]}));
    chk("a_abort_clr", 256'({ir_a, ov_a, fd_a}), 256'(3'b100));

    // Second full frame after the clear: anchor and pointers restart.
    qa.delete();
    wptr = 0;
    for (int i = 0; i < 98; i++) send_a(8'($urandom_range(0, 255)), 1'b0);
    for (int t = 0; t < 12000 && !fd_a; t++) tick(1);
    chk("a2_frame_done", 256'(fd_a), 256'(1));
    chk("a2_no_ovf", 256'(ov_a), 256'(0));
    chkq = qa;
    check_frame("a2", 28, 28, 3);

    // 8x6, K=5, 8-bit pixels: bytes 0..47 loaded before the core is ready.
    wptr = 0;
    for (int i = 0; i < 48; i++) send_b(8'(i));
    tick(5);
    chk("b_hold_no_rdy", 256'(qb.size()), 256'(0));
    n0 = cyc;
    wr_b = 1'b1;
    for (int t = 0; t < 20 && qb.size() == 0; t++) tick(1);
    chk("b_start_latency", 256'(qb.size() > 0 ? qb[0].cyc : 32'd0), 256'(n0 + 1 + LAT));
    for (int t = 0; t < 2000 && !fd_b; t++) tick(1);
    chk("b_frame_done", 256'(fd_b), 256'(1));
    chkq = qb;
    check_frame("b", 8, 6, 5);

    // A byte arriving with the frame full is dropped.
    chk("b_no_ovf_yet", 256'(ov_b), 256'(0));
    iv_b = 1'b1; id_b = 8'hAA;
    tick(1);
    iv_b = 1'b0;
    tick(3);
    chk("b_ovf_full", 256'({ov_b, ir_b, fd_b}), 256'(3'b111));
    chk("b_no_more_pix", 256'(qb.size()), 256'(200));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
